spi_master_mmio: RTL

Parametrised memory-mapped SPI master for the soft-CPU peripheral bus. It succeeds the fixed 8-bit, mode-0, single-CS SPI peripheral.
- Adds programmable frame length (1..MAX_BITS), all four CPOL/CPHA modes, and LSB/MSB-first ordering.
- Adds a 16-bit clock divider, NUM_CS one-hot chip selects with optional CS hold between frames, and sticky RX overrun detection.
- Sits on the same mem_valid/mem_addr/mem_wdata/mem_wmask bus as the other MMIO peripherals.

---
 rtl/spi_master_pkg.sv | 51 +++++
 rtl/spi_clk_div.sv | 45 ++++
 rtl/spi_master_mmio.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_pkg
// Purpose  : Shared definitions for the memory-mapped SPI master: register
//            offsets, CTRL/STATUS bit positions, FSM state type, CLKDIV reset
//            value and the bit-ordering helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package spi_master_pkg;

  // Register byte offsets inside the 4 KiB block
  localparam logic [11:0] c_OFF_CTRL   = 12'h000;
  localparam logic [11:0] c_OFF_CLKDIV = 12'h004;
  localparam logic [11:0] c_OFF_TXDATA = 12'h008;
  localparam logic [11:0] c_OFF_RXDATA = 12'h00C;
  localparam logic [11:0] c_OFF_STATUS = 12'h010;

  // CTRL bit positions
  localparam int c_CTRL_EN     = 0;
  localparam int c_CTRL_START  = 1;
  localparam int c_CTRL_CPOL   = 2;
  localparam int c_CTRL_CPHA   = 3;
  localparam int c_CTRL_LSB    = 4;
  localparam int c_CTRL_HOLD   = 5;
  localparam int c_CTRL_IE     = 6;
  localparam int c_CTRL_LEN_LO = 8;
  localparam int c_CTRL_CS_LO  = 16;

  // STATUS bit positions
  localparam int c_STAT_BUSY = 0;
  localparam int c_STAT_DONE = 1;
  localparam int c_STAT_OVR  = 2;

  localparam logic [15:0] c_CLKDIV_RST = 16'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } state_e;

  // Register bit index of the k-th bit on the wire for a frame of len+1 bits.
  function automatic logic [4:0] bit_pos(input logic lsb_first, input logic [4:0] len,
                                         input logic [4:0] k);
    return lsb_first ? k : (len - k);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module   : spi_clk_div
// Purpose  : 16-bit half-period counter. Emits a one-cycle tick whenever the
//            count reaches div_i, then restarts from zero.
// Ports    : clk, resetn    - clock, async active-low reset
//            load_i         - restart count at zero (frame start)
//            en_i           - count enable
//            div_i[15:0]    - terminal count (half-period = div_i+1 cycles)
//            tick_o         - half-period tick
// Revision : 1.0 - initial release
// ============================================================================
module spi_clk_div (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [15:0] div_i,
  output logic        tick_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick_o = en_i & ~load_i & (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? 16'd0 : (cnt_q + 16'd1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master_mmio.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_mmio
// Purpose  : Memory-mapped SPI master: programmable frame length, CPOL/CPHA,
//            bit order, clock divider, one-hot chip selects with optional hold
//            and sticky RX overrun. Optional interrupt output when the macro
//            SPI_MASTER_IRQ_EN is defined.
// Ports    : clk, resetn              - clock, async active-low reset
//            mem_valid/addr/wdata/wmask - peripheral bus (wmask!=0 => write)
//            mem_rdata                - combinational read data
//            spi_sclk/mosi/miso       - serial lines
//            spi_cs_n[NUM_CS-1:0]     - active-low chip selects
//            irq                      - DONE & IE (SPI_MASTER_IRQ_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_mmio
  import spi_master_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2000_1000,
  parameter int          NUM_CS    = 4,
  parameter int          MAX_BITS  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wmask,
  output logic [31:0]       mem_rdata,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
`ifdef SPI_MASTER_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [4:0] c_LEN_MAX = 5'(MAX_BITS - 1);

  state_e state_q, state_d;

  // Programmer-visible registers
  logic              en_q, cpol_q, cpha_q, lsb_q, hold_q;
  logic [4:0]        len_q;
  logic [2:0]        cs_sel_q;
  logic [15:0]       clkdiv_q;
  logic [31:0]       txdata_q, rxdata_q;
  logic              done_q, ovr_q, unread_q;
  // Per-frame working copies
  logic              cur_cpha_q, cur_lsb_q, cur_hold_q;
  logic [4:0]        cur_len_q;
  logic [15:0]       cur_div_q;
  logic [31:0]       cur_tx_q, rx_sh_q;
  logic [5:0]        edge_q;
  logic              sclk_q, mosi_q;
  logic [NUM_CS-1:0] cs_n_q;

  logic [11:0]       w_off;
  logic              w_sel, w_wr, w_rd, w_busy, w_start, w_tick, w_edge;
  logic              w_last_edge, w_done_evt, w_lead, w_ie;
  logic [4:0]        w_len_wr, w_k, w_pos_cur, w_pos_nxt;
  logic [NUM_CS-1:0] w_cs_dec;

  assign w_off  = mem_addr[11:0];
  assign w_sel  = mem_valid && (mem_addr[31:12] == BASE_ADDR[31:12]);
  assign w_wr   = w_sel && (mem_wmask != 4'b0000);
  assign w_rd   = w_sel && (mem_wmask == 4'b0000);
  assign w_busy = (state_q != IDLE);

  assign w_len_wr = ({27'd0, mem_wdata[12:8]} >= 32'(MAX_BITS)) ? c_LEN_MAX : mem_wdata[12:8];
  assign w_start  = w_wr && !w_busy && (w_off == c_OFF_CTRL) &&
                    mem_wdata[c_CTRL_EN] && mem_wdata[c_CTRL_START];

  // Edge 0 is issued as LEAD ends; the remaining 2*(LEN+1)-1 edges in SHIFT.
  assign w_edge      = w_tick && ((state_q == LEAD) || (state_q == SHIFT));
  assign w_last_edge = (edge_q == {cur_len_q, 1'b1});
  assign w_done_evt  = w_tick && (state_q == TRAIL);
  assign w_lead      = ~edge_q[0];
  assign w_k         = edge_q[5:1];
  assign w_pos_cur   = bit_pos(cur_lsb_q, cur_len_q, w_k);
  assign w_pos_nxt   = bit_pos(cur_lsb_q, cur_len_q, w_k + 5'd1);

  // Out-of-range CS_SEL decodes to no select at all
  for (genvar i = 0; i < NUM_CS; i++) begin : g_cs_dec
    assign w_cs_dec[i] = (mem_wdata[18:16] != 3'(i));
  end

  spi_clk_div u_div (
    .clk    (clk),
    .resetn (resetn),
    .load_i (w_start),
    .en_i   (w_busy),
    .div_i  (cur_div_q),
    .tick_o (w_tick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_start) state_d = LEAD;
      LEAD:    if (w_tick) state_d = SHIFT;
      SHIFT:   if (w_tick && w_last_edge) state_d = TRAIL;
      TRAIL:   if (w_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_q <= 1'b0; cpol_q <= 1'b0; cpha_q <= 1'b0; lsb_q <= 1'b0; hold_q <= 1'b0;
      len_q <= '0; cs_sel_q <= '0; clkdiv_q <= c_CLKDIV_RST; txdata_q <= '0; rxdata_q <= '0;
      done_q <= 1'b0; ovr_q <= 1'b0; unread_q <= 1'b0;
      cur_cpha_q <= 1'b0; cur_lsb_q <= 1'b0; cur_hold_q <= 1'b0; cur_len_q <= '0;
      cur_div_q <= '0; cur_tx_q <= '0; rx_sh_q <= '0; edge_q <= '0;
      sclk_q <= 1'b0; mosi_q <= 1'b0; cs_n_q <= '1;
    end else begin
      if (w_wr && !w_busy && (w_off == c_OFF_CTRL)) begin
        en_q     <= mem_wdata[c_CTRL_EN];
        cpol_q   <= mem_wdata[c_CTRL_CPOL];
        cpha_q   <= mem_wdata[c_CTRL_CPHA];
        lsb_q    <= mem_wdata[c_CTRL_LSB];
        hold_q   <= mem_wdata[c_CTRL_HOLD];
        len_q    <= w_len_wr;
        cs_sel_q <= mem_wdata[18:16];
      end
      if (w_wr && !w_busy && (w_off == c_OFF_CLKDIV)) clkdiv_q <= mem_wdata[15:0];
      if (w_wr && !w_busy && (w_off == c_OFF_TXDATA)) txdata_q <= mem_wdata;

      if (w_start) begin
        cur_cpha_q <= mem_wdata[c_CTRL_CPHA];
        cur_lsb_q  <= mem_wdata[c_CTRL_LSB];
        cur_hold_q <= mem_wdata[c_CTRL_HOLD];
        cur_len_q  <= w_len_wr;
        cur_div_q  <= clkdiv_q;
        cur_tx_q   <= txdata_q;
        rx_sh_q    <= '0;
        edge_q     <= '0;
        sclk_q     <= mem_wdata[c_CTRL_CPOL];
        cs_n_q     <= w_cs_dec;
        // CPHA=0 needs the first bit on the wire before the first edge
        if (!mem_wdata[c_CTRL_CPHA]) begin
          mosi_q <= txdata_q[bit_pos(mem_wdata[c_CTRL_LSB], w_len_wr, 5'd0)];
        end
      end else if (!w_busy) begin
        sclk_q <= cpol_q;
      end

      if (w_edge) begin
        sclk_q <= ~sclk_q;
        edge_q <= edge_q + 6'd1;
        if (!cur_cpha_q) begin
          if (w_lead) rx_sh_q[w_pos_cur] <= spi_miso;
          else if (w_k != cur_len_q) mosi_q <= cur_tx_q[w_pos_nxt];
        end else begin
          if (w_lead) mosi_q <= cur_tx_q[w_pos_cur];
          else rx_sh_q[w_pos_cur] <= spi_miso;
        end
      end

      if (w_done_evt) begin
        rxdata_q <= rx_sh_q;
        if (!cur_hold_q) cs_n_q <= '1;
      end

      // Completion has priority over W1C / start clears. START always clears
      // DONE, so the unread flag alone tells whether a prior result is pending.
      if (w_done_evt) done_q <= 1'b1;
      else if (w_start || (w_wr && (w_off == c_OFF_STATUS) && mem_wdata[c_STAT_DONE])) done_q <= 1'b0;

      if (w_done_evt && unread_q) ovr_q <= 1'b1;
      else if (w_wr && (w_off == c_OFF_STATUS) && mem_wdata[c_STAT_OVR]) ovr_q <= 1'b0;

      if (w_done_evt) unread_q <= 1'b1;
      else if (w_rd && (w_off == c_OFF_RXDATA)) unread_q <= 1'b0;
    end
  end

`ifdef SPI_MASTER_IRQ_EN
  logic ie_q, irq_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (w_wr && !w_busy && (w_off == c_OFF_CTRL)) ie_q <= mem_wdata[c_CTRL_IE];
      irq_q <= done_q & ie_q;
    end
  end
  assign w_ie = ie_q;
  assign irq  = irq_q;
`else
  assign w_ie = 1'b0;
`endif

  always_comb begin
    mem_rdata = '0;
    if (w_sel) begin
      case (w_off)
        c_OFF_CTRL:   mem_rdata = {13'd0, cs_sel_q, 3'd0, len_q, 1'b0, w_ie, hold_q,
                                   lsb_q, cpha_q, cpol_q, 1'b0, en_q};
        c_OFF_CLKDIV: mem_rdata = {16'd0, clkdiv_q};
        c_OFF_TXDATA: mem_rdata = txdata_q;
        c_OFF_RXDATA: mem_rdata = rxdata_q;
        c_OFF_STATUS: mem_rdata = {29'd0, ovr_q, done_q, w_busy};
        default:      mem_rdata = '0;
      endcase
    end
  end

  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

endmodule
`default_nettype wire
